// File: rtl/int_pkg.sv
// Shared encodings for the exception/interrupt path: Ecodes, interrupt cause
// codes and the responder state encoding also decoded by the interrupt controller.
package int_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [5:0] INT_EXT0  = 6'd0;
    localparam logic [5:0] INT_TIMER = 6'd11;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } int_state_e;

endpackage

// File: rtl/int_responder.sv
// Exception/interrupt response unit at WB: saves context on entry, flushes and
// redirects to EENTRY, holds in_exception until ertn, then returns to ERA.
module int_responder
    import int_pkg::*;
#(
    parameter logic [31:0] EENTRY_RESET = 32'h1C00_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_exc,
    input  logic [5:0]  wb_ecode,
    input  logic        wb_ertn,
    input  logic        int_req,
    input  logic [5:0]  int_cause,
    input  logic        csr_ie_we,
    input  logic        csr_ie_wdata,
    input  logic        csr_eentry_we,
    input  logic [31:0] csr_eentry_wdata,
    output logic        mie,
    output logic        pie,
    output logic [31:0] era,
    output logic [5:0]  ecode,
    output logic [5:0]  int_cause_q,
    output logic [31:0] eentry,
    output logic        in_exception,
    output logic        flush,
    output logic        ertn,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    int_state_e  state_q, state_d;
    logic        mie_q, mie_d;
    logic        pie_q, pie_d;
    logic [31:0] era_q, era_d;
    logic [5:0]  ecode_q, ecode_d;
    logic [5:0]  cause_q, cause_d;
    logic [31:0] eentry_q, eentry_d;

    logic take, exc_take, int_take, ret_take;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            mie_q    <= 1'b0;
            pie_q    <= 1'b0;
            era_q    <= 32'h0;
            ecode_q  <= 6'h0;
            cause_q  <= 6'h0;
            eentry_q <= EENTRY_RESET;
        end else begin
            state_q  <= state_d;
            mie_q    <= mie_d;
            pie_q    <= pie_d;
            era_q    <= era_d;
            ecode_q  <= ecode_d;
            cause_q  <= cause_d;
            eentry_q <= eentry_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mie_d          = mie_q;
        pie_d          = pie_q;
        era_d          = era_q;
        ecode_d        = ecode_q;
        cause_d        = cause_q;
        eentry_d       = eentry_q;
        flush          = 1'b0;
        ertn           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        in_exception   = 1'b0;

        // The instruction in WB during ENTER/RETURN is being flushed, so it is ignored.
        take     = wb_valid && (state_q == ST_RUN || state_q == ST_HANDLER);
        exc_take = take && wb_exc;
        int_take = take && !wb_exc && int_req && mie_q && (state_q == ST_RUN);
        ret_take = take && !wb_exc && !int_take && wb_ertn;

        case (state_q)
            ST_ENTER: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = eentry_q;
                in_exception   = 1'b1;
                state_d        = ST_HANDLER;
            end
            ST_RETURN: begin
                flush          = 1'b1;
                ertn           = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = era_q;
                state_d        = ST_RUN;
            end
            ST_HANDLER: in_exception = 1'b1;
            default: ;
        endcase

        // Re-entry from HANDLER overwrites ERA/PIE: handlers do not nest.
        if (exc_take || int_take) begin
            era_d   = wb_pc;
            pie_d   = mie_q;
            mie_d   = 1'b0;
            ecode_d = exc_take ? wb_ecode : ECODE_INT;
            if (int_take)
                cause_d = int_cause;
            state_d = ST_ENTER;
        end else if (ret_take) begin
            mie_d   = pie_q;
            state_d = ST_RETURN;
        end else if (take) begin
            if (csr_ie_we)
                mie_d = csr_ie_wdata;
            if (csr_eentry_we)
                eentry_d = csr_eentry_wdata;
        end
    end

    assign mie         = mie_q;
    assign pie         = pie_q;
    assign era         = era_q;
    assign ecode       = ecode_q;
    assign int_cause_q = cause_q;
    assign eentry      = eentry_q;

endmodule

// File: doc/int_responder.md
Name: int_responder

Overview:
- Exception/interrupt response unit. It consumes the interrupt controller's request (int_req, int_cause) and synchronous exceptions and ertn from WB.
- It saves context (ERA, PRMD.PIE, Ecode) and clears the global interrupt enable. It then pulses flush and redirects fetch to EENTRY.
- It holds in_exception until ertn, then restores state and redirects to ERA.
- It drives the mie, flush, ertn and in_exception inputs of the interrupt controller. It sits beside the CSR file at the WB stage.

Parameters:
EENTRY_RESET, 32'h1C00_0100, reset value of the exception entry address register.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
wb_valid  input  1  WB-stage instruction valid
wb_pc  input  32  WB-stage PC
wb_exc  input  1  WB instruction raised a synchronous exception
wb_ecode  input  6  Ecode of that exception
wb_ertn  input  1  WB instruction is ertn
int_req  input  1  interrupt request from the interrupt controller
int_cause  input  6  interrupt cause code from the interrupt controller
csr_ie_we  input  1  WB CSR write to CRMD.IE
csr_ie_wdata  input  1  new IE value
csr_eentry_we  input  1  WB CSR write to EENTRY
csr_eentry_wdata  input  32  new EENTRY value
mie  output  1  CRMD.IE, global interrupt enable
pie  output  1  PRMD.PIE, saved IE
era  output  32  exception return address
ecode  output  6  ESTAT.Ecode of the last entry
int_cause_q  output  6  cause latched at interrupt entry
eentry  output  32  exception entry address
in_exception  output  1  handler active
flush  output  1  one-cycle pipeline flush
ertn  output  1  one-cycle return pulse, coincident with flush
redirect_valid  output  1  fetch redirect, coincident with flush
redirect_pc  output  32  redirect target

Behaviour:
- Reset values:
  - state=RUN; mie=0, pie=0, era=0, ecode=0, int_cause_q=0.
  - eentry=EENTRY_RESET.
  - in_exception=0, flush=0, ertn=0, redirect_valid=0, redirect_pc=0.
  - Reset asserted in any state returns to these values immediately.
- States: RUN, ENTER, HANDLER, RETURN. ENTER and RETURN each last exactly one cycle.
- Accepted events (sampled only when wb_valid=1 and state is RUN or HANDLER):
  - Exception: wb_exc=1.
  - Interrupt: int_req=1 and mie=1 and state=RUN.
  - Return: wb_ertn=1 and wb_exc=0.
- Priority within one cycle: exception > interrupt > return > CSR writes.
- On exception or interrupt at cycle N (all updates registered):
  - era<=wb_pc; pie<=mie; mie<=0.
  - ecode<=wb_exc ? wb_ecode : ECODE_INT (0).
  - int_cause_q<=int_cause on interrupt only; it holds its value on an exception.
  - Next state is ENTER.
- ENTER (cycle N+1): flush=1, redirect_valid=1, redirect_pc=eentry, in_exception=1. Next state is HANDLER.
- HANDLER: in_exception=1. A new sync exception re-enters: era is overwritten and pie<=mie. This is non-nesting; loss of the earlier ERA is the defined behaviour.
- On return at cycle N: mie<=pie; next state is RETURN.
- RETURN (cycle N+1): flush=1, ertn=1, redirect_valid=1, redirect_pc=era, in_exception=0. Next state is RUN.
- ertn executed in RUN is legal and follows the same path.
- CSR writes:
  - Applied only in RUN or HANDLER, only when wb_valid=1 and no exception, interrupt or return is taken that cycle.
  - csr_ie_we updates mie; csr_eentry_we updates eentry.
  - Writes issued in ENTER or RETURN are ignored, because those instructions are flushed.
- All WB inputs are ignored in ENTER and RETURN.
- Interrupt latency: int_req sampled at N gives flush/redirect at N+1. The controller's pending state clears on that flush.
- int_req while mie=0, wb_valid=0 or state≠RUN produces no effect.

Decomposition:
- Shared package int_pkg holds:
  - ECODE_INT=6'h00, ECODE_SYS=6'h0B, ECODE_BRK=6'h0C, ECODE_INE=6'h0D, ECODE_ADE=6'h08, ECODE_ALE=6'h09.
  - Cause codes INT_EXT0=0, INT_TIMER=11.
  - The 2-bit state encoding, shared with the interrupt controller.
- Single module; no sub-module is natural.

Test Plan:
1. Interrupt entry: csr_ie_we=1/wdata=1, then int_req=1, int_cause=11, wb_pc=32'h1C00_0040 → next cycle flush=1, redirect_pc=32'h1C00_0100, era=32'h1C00_0040, ecode=0, int_cause_q=11, mie=0, pie=1, in_exception=1.
2. Return: continue from 1, wb_ertn=1 in HANDLER → next cycle flush=1, ertn=1, redirect_pc=32'h1C00_0040, mie=1, in_exception=0; state RUN one cycle later.
3. Priority: wb_exc=1, wb_ecode=6'h0B, int_req=1, wb_ertn=1, csr_ie_we=1 in the same cycle at wb_pc=32'h1C00_0080 → ecode=6'h0B, era=32'h1C00_0080, int_cause_q unchanged, mie=0.
4. Masked interrupt: int_req=1 with mie=0 for 5 cycles, and int_req=1 with wb_valid=0 → flush, redirect_valid and in_exception stay 0.
5. Re-entry and EENTRY: csr_eentry_wdata=32'h1C00_2000 in RUN, then wb_exc at 32'h1C00_0100, then wb_exc at 32'h1C00_2004 in HANDLER → both redirects go to 32'h1C00_2000; final era=32'h1C00_2004, pie=0.
6. Reset mid-operation: assert reset in HANDLER → all outputs return to reset values asynchronously; after release, int_req is ignored until mie is rewritten.
